exec_pipe_ctrl: RTL and testbench

- Sequences the execute stage of the RV32 core: accepts decoded instructions from ID with a valid/ready handshake and holds EX-resident instruction state (rd, class).
- Drives the execute stage's stall input; inserts load-use bubbles; holds EX for multi-cycle M-extension ops and outstanding loads.
- Flushes EX on a taken branch.
- Sits between decode and the execute stage.

---
 rtl/exec_pipe_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_exec_pipe_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_pipe_ctrl.sv
// exec_pipe_ctrl: execute-stage sequencer between decode and EX.
// Accepts ID instructions on a valid/ready handshake and tracks what is
// resident in EX. It stalls EX for M-extension ops and outstanding loads,
// inserts load-use bubbles and kills EX/ID on a taken branch.
// Optional feature macro: STALL_CNT_EN adds the stall_cnt[31:0] output.
//
// state | meaning
// RUN   | normal issue, one instruction per cycle
// MULTI | M-extension op resident, EX frozen while the down-counter runs
// LWAIT | load resident, EX frozen until mem_ready
// FLUSH | one-cycle kill after a taken branch
module exec_pipe_ctrl #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 6
) (
  input  logic        req,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [6:0]  id_opcode,
  input  logic [6:0]  id_funct7,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_ready,
  output logic        ex_valid,
  output logic        ex_stall,
  output logic        ex_flush,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_write,
  output logic        muldiv_busy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_MULTI, ST_LWAIT, ST_FLUSH} state_t;
  typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_MULDIV} iclass_t;

  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_LAT - 1);

  state_t           r_state, w_state_nxt;
  iclass_t          r_ex_class, w_class_nxt, w_id_class;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ex_valid, w_valid_nxt;
  logic             r_ex_stall, w_stall_nxt;
  logic             r_ex_flush, w_flush_nxt;
  logic [4:0]       r_ex_rd, w_rd_nxt;
  logic             r_ex_rd_write, w_rdw_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_hazard;
  logic             w_flush_take;
  logic             w_issue;

  // Decode the instruction class presented by ID.
  always_comb begin
    w_id_class = CL_ALU;
    case (id_opcode)
      7'b0000011: w_id_class = CL_LOAD;
      7'b1100011: w_id_class = CL_BRANCH;
      7'b0100011: w_id_class = CL_STORE;
      7'b0110011: w_id_class = (id_funct7 == 7'b0000001) ? CL_MULDIV : CL_ALU;
      default:    w_id_class = CL_ALU;
    endcase
  end

  assign w_hazard = r_ex_valid && (r_ex_class == CL_LOAD) && (r_ex_rd != 5'd0) &&
                    ((id_rs1 == r_ex_rd) || (id_rs2 == r_ex_rd));
  assign id_ready = (r_state == ST_RUN) && !w_hazard && !r_ex_flush;
  // A taken branch beats issue: whatever sits in ID this cycle is wrong-path.
  assign w_flush_take = (r_state == ST_RUN) && r_ex_valid && (r_ex_class == CL_BRANCH) &&
                        ex_branch_taken;
  assign w_issue = id_valid && id_ready && !w_flush_take;

  // Next-state and next registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_ex_valid;
    w_rd_nxt    = r_ex_rd;
    w_rdw_nxt   = r_ex_rd_write;
    w_class_nxt = r_ex_class;
    w_stall_nxt = r_ex_stall;
    w_flush_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_RUN: begin
        if (w_flush_take) begin
          w_state_nxt = ST_FLUSH;
          w_flush_nxt = 1'b1;
          w_valid_nxt = 1'b0;
          w_rdw_nxt   = 1'b0;
        end else if (w_issue) begin
          w_valid_nxt = 1'b1;
          w_rd_nxt    = id_rd;
          w_class_nxt = w_id_class;
          w_rdw_nxt   = (w_id_class != CL_BRANCH) && (w_id_class != CL_STORE) &&
                        (id_rd != 5'd0);
          if (w_id_class == CL_MULDIV) begin
            w_state_nxt = ST_MULTI;
            w_cnt_nxt   = MULDIV_LOAD;
            w_stall_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end else if (w_id_class == CL_LOAD) begin
            w_state_nxt = ST_LWAIT;
            w_stall_nxt = 1'b1;
          end
        end else begin
          w_valid_nxt = 1'b0;
          w_rdw_nxt   = 1'b0;
        end
      end
      ST_MULTI: begin
        // The op retires as the stall drops, leaving EX empty for one cycle.
        if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
          w_stall_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_valid_nxt = 1'b0;
          w_rdw_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_LWAIT: begin
        // The load retires with its data; the empty EX cycle that follows is
        // the bubble that covers a dependent consumer in ID.
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_stall_nxt = 1'b0;
          w_valid_nxt = 1'b0;
          w_rdw_nxt   = 1'b0;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_ex_valid    <= 1'b0;
      r_ex_stall    <= 1'b0;
      r_ex_flush    <= 1'b0;
      r_ex_rd       <= 5'd0;
      r_ex_rd_write <= 1'b0;
      r_ex_class    <= CL_ALU;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ex_valid    <= w_valid_nxt;
      r_ex_stall    <= w_stall_nxt;
      r_ex_flush    <= w_flush_nxt;
      r_ex_rd       <= w_rd_nxt;
      r_ex_rd_write <= w_rdw_nxt;
      r_ex_class    <= w_class_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_stall    = r_ex_stall;
  assign ex_flush    = r_ex_flush;
  assign ex_rd       = r_ex_rd;
  assign ex_rd_write = r_ex_rd_write;
  assign muldiv_busy = r_busy;

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_bubble;

  assign w_bubble = (r_state == ST_RUN) && id_valid && w_hazard && !w_flush_take;

  // Count every edge spent stalled or spent inserting a load-use bubble.
  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (r_ex_stall || w_bubble) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_exec_pipe_ctrl.sv
// Directed bench for exec_pipe_ctrl: reset, ALU issue, load stalls and
// bubbles, multi-cycle M ops, branch flush and asynchronous reset mid-op.
module tb_exec_pipe_ctrl;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] F7_M     = 7'b0000001;

  logic       req = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic       id_ready;
  logic [6:0] id_opcode;
  logic [6:0] id_funct7;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken;
  logic       mem_ready;
  logic       ex_valid, ex_stall, ex_flush, ex_rd_write, muldiv_busy;
  logic [4:0] ex_rd;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] snap;
`endif

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int n_ok;

  exec_pipe_ctrl #(.MULDIV_LAT(32), .CNT_W(6)) dut (
    .req(req), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .ex_rd(ex_rd), .ex_rd_write(ex_rd_write), .muldiv_busy(muldiv_busy)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 req = ~req;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge req);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    id_valid  = v;
    id_opcode = op;
    id_funct7 = f7;
    id_rs1    = s1;
    id_rs2    = s2;
    id_rd     = d;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    drive(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_stall", ex_stall, 0);
    chk("rst_flush", ex_flush, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_rdw", ex_rd_write, 0);
    chk("rst_busy", muldiv_busy, 0);
    chk("rst_ready", id_ready, 1);
`ifdef STALL_CNT_EN
    chk("rst_stallcnt", stall_cnt, 0);
`endif
    step();
    rst_n = 1'b1;

    // back-to-back ALU ops
    drive(1'b1, OP_ALU, 7'd0, 5'd1, 5'd2, 5'd5);
    #1 chk("add5_ready", id_ready, 1);
    step();
    chk("add5_valid", ex_valid, 1);
    chk("add5_rd", ex_rd, 5);
    chk("add5_rdw", ex_rd_write, 1);
    chk("add5_stall", ex_stall, 0);
    drive(1'b1, OP_ALU, 7'd0, 5'd1, 5'd2, 5'd6);
    step();
    chk("add6_valid", ex_valid, 1);
    chk("add6_rd", ex_rd, 6);
    chk("add6_stall", ex_stall, 0);
    drive(1'b1, OP_ALU, 7'd0, 5'd1, 5'd2, 5'd0);
    step();
    chk("addx0_rdw", ex_rd_write, 0);
    drive(1'b1, OP_STORE, 7'd0, 5'd1, 5'd2, 5'd3);
    step();
    chk("store_valid", ex_valid, 1);
    chk("store_rdw", ex_rd_write, 0);
    drive(1'b0, OP_ALU, 7'd0, 5'd0, 5'd0, 5'd0);
    step();
    chk("idle_bubble", ex_valid, 0);

    // LW x7 then dependent ADD, memory answers immediately
    drive(1'b1, OP_LOAD, 7'd0, 5'd1, 5'd0, 5'd7);
    step();
    chk("lw_valid", ex_valid, 1);
    chk("lw_rd", ex_rd, 7);
    chk("lw_stall", ex_stall, 1);
    drive(1'b1, OP_ALU, 7'd0, 5'd7, 5'd1, 5'd8);
    #1 chk("lw_ready", id_ready, 0);
    step();
    chk("lw_bubble", ex_valid, 0);
    chk("lw_unstall", ex_stall, 0);
    #1 chk("lw_ready2", id_ready, 1);
    step();
    chk("use_valid", ex_valid, 1);
    chk("use_rd", ex_rd, 8);

    // LW with memory held off for four cycles
`ifdef STALL_CNT_EN
    snap = stall_cnt;
`endif
    mem_ready = 1'b0;
    drive(1'b1, OP_LOAD, 7'd0, 5'd2, 5'd0, 5'd7);
    step();
    drive(1'b1, OP_ALU, 7'd0, 5'd1, 5'd7, 5'd8);
    n_ok = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ex_stall === 1'b1 && ex_valid === 1'b1 && id_ready === 1'b0) n_ok++;
    end
    chk("lwait_hold", n_ok, 4);
    mem_ready = 1'b1;
    step();
    chk("lwait_exit_stall", ex_stall, 0);
    chk("lwait_exit_valid", ex_valid, 0);
    step();
    chk("lwait_use_rd", ex_rd, 8);
    chk("lwait_use_valid", ex_valid, 1);
`ifdef STALL_CNT_EN
    chk("stallcnt_delta", stall_cnt - snap, 5);
`endif

    // MUL x9 occupies EX for 32 cycles
    drive(1'b1, OP_ALU, F7_M, 5'd3, 5'd4, 5'd9);
    step();
    chk("mul_busy", muldiv_busy, 1);
    chk("mul_stall", ex_stall, 1);
    chk("mul_rd", ex_rd, 9);
    drive(1'b1, OP_ALU, 7'd0, 5'd1, 5'd2, 5'd10);
    n_ok = 0;
    for (int i = 0; i < 31; i++) begin
      step();
      if (ex_stall === 1'b1 && muldiv_busy === 1'b1 && id_ready === 1'b0 &&
          ex_valid === 1'b1) n_ok++;
    end
    chk("mul_hold", n_ok, 31);
    step();
    chk("mul_done_busy", muldiv_busy, 0);
    chk("mul_done_stall", ex_stall, 0);
    #1 chk("mul_done_ready", id_ready, 1);
    step();
    chk("after_mul_valid", ex_valid, 1);
    chk("after_mul_rd", ex_rd, 10);

    // taken branch flushes for one cycle
    drive(1'b1, OP_BR, 7'd0, 5'd1, 5'd2, 5'd4);
    step();
    chk("beq_valid", ex_valid, 1);
    chk("beq_rdw", ex_rd_write, 0);
    ex_branch_taken = 1'b1;
    drive(1'b1, OP_ALU, 7'd0, 5'd1, 5'd2, 5'd11);
    step();
    chk("flush_on", ex_flush, 1);
    chk("flush_valid", ex_valid, 0);
    #1 chk("flush_ready", id_ready, 0);
    ex_branch_taken = 1'b0;
    step();
    chk("flush_off", ex_flush, 0);
    chk("flush_after_valid", ex_valid, 0);
    step();
    chk("post_flush_rd", ex_rd, 11);
    chk("post_flush_valid", ex_valid, 1);

    // not-taken branch keeps issuing
    drive(1'b1, OP_BR, 7'd0, 5'd1, 5'd2, 5'd4);
    step();
    drive(1'b1, OP_ALU, 7'd0, 5'd1, 5'd2, 5'd12);
    step();
    chk("nt_flush", ex_flush, 0);
    chk("nt_rd", ex_rd, 12);

    // asynchronous reset with the MUL counter at 10
    drive(1'b1, OP_ALU, F7_M, 5'd1, 5'd2, 5'd13);
    step();
    drive(1'b0, OP_ALU, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (21) step();
    chk("mid_mul_busy", muldiv_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_stall", ex_stall, 0);
    chk("arst_busy", muldiv_busy, 0);
    chk("arst_rd", ex_rd, 0);
    chk("arst_ready", id_ready, 1);
`ifdef STALL_CNT_EN
    chk("arst_stallcnt", stall_cnt, 0);
`endif
    step();
    rst_n = 1'b1;
    drive(1'b1, OP_ALU, 7'd0, 5'd1, 5'd2, 5'd14);
    step();
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_rd", ex_rd, 14);
    chk("post_rst_stall", ex_stall, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
